// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-aligned word updates.
// Optional digit blinking is built when SSD_BLINK_EN is defined.
module ssd_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] sym_word,
    input  logic        sym_valid,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SYM_W      = 5;
    localparam int unsigned WORD_W     = 4 * SYM_W;
    localparam logic [WORD_W-1:0] BLANK_WORD = {4{5'd10}};
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    logic [PW-1:0]     pre_cnt;
    logic [1:0]        idx;
    logic [WORD_W-1:0] pend_word;
    logic [WORD_W-1:0] disp_word;
    logic              pend_flag;
    logic              pre_wrap_c;
    logic              frame_wrap_c;
    logic [SYM_W-1:0]  sym_sel_c;
    logic              blank_c;

    function automatic logic [6:0] sym_decode(input logic [SYM_W-1:0] s);
        logic [6:0] r;
        r = SEG_BLANK;
        case (s)
            5'd0:  r = 7'h01;
            5'd1:  r = 7'h4F;
            5'd2:  r = 7'h12;
            5'd3:  r = 7'h06;
            5'd4:  r = 7'h4C;
            5'd5:  r = 7'h24;
            5'd6:  r = 7'h20;
            5'd7:  r = 7'h0F;
            5'd8:  r = 7'h00;
            5'd9:  r = 7'h04;
            5'd11: r = 7'h48;
            5'd12: r = 7'h6A;
            5'd13: r = 7'h71;
            5'd14: r = 7'h30;
            5'd15: r = 7'h31;
            5'd16: r = 7'h08;
            5'd17: r = 7'h7E;
            5'd18: r = 7'h18;
            5'd19: r = 7'h24;
            5'd20: r = 7'h42;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

    always_comb begin
        pre_wrap_c   = (pre_cnt == PW'(REFRESH_DIV - 1));
        frame_wrap_c = pre_wrap_c && (idx == 2'd3);
    end

    // Prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= 2'd0;
        end else if (pre_wrap_c) begin
            pre_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Pending capture; the display word only changes at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_word <= BLANK_WORD;
            pend_flag <= 1'b0;
            disp_word <= BLANK_WORD;
        end else if (frame_wrap_c) begin
            pend_flag <= 1'b0;
            if (sym_valid) begin
                pend_word <= sym_word;
                disp_word <= sym_word;
            end else if (pend_flag) begin
                disp_word <= pend_word;
            end
        end else if (sym_valid) begin
            pend_word <= sym_word;
            pend_flag <= 1'b1;
        end
    end

    always_comb begin
        sym_sel_c = disp_word[SYM_W-1:0];
        case (idx)
            2'd0: sym_sel_c = disp_word[4:0];
            2'd1: sym_sel_c = disp_word[9:5];
            2'd2: sym_sel_c = disp_word[14:10];
            2'd3: sym_sel_c = disp_word[19:15];
            default: sym_sel_c = disp_word[4:0];
        endcase
    end

`ifdef SSD_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    // Blink phase flips once per BLINK_DIV cycles, starting in the on phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        blank_c = ~blink_on && blink_mask[idx];
    end
`else
    logic unused_blink_c;

    always_comb begin
        blank_c        = 1'b0;
        unused_blink_c = ^blink_mask;
    end
`endif

    // Registered display outputs track the index with one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(4'b0001 << idx);
            seg        <= blank_c ? SEG_BLANK : sym_decode(sym_sel_c);
            frame_done <= frame_wrap_c;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized bench for ssd_scan_driver against a cycle-count reference model.
// Honours SSD_BLINK_EN the same way the design does.
module tb_ssd_scan_driver;

    localparam int unsigned RDIV  = 4;
    localparam int unsigned BDIV  = 16;
    localparam int unsigned FRAME = 4 * RDIV;

    logic        clk;
    logic        rst;
    logic [19:0] sym_word;
    logic        sym_valid;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since reset release, pending/display words, capture flag
    int          n;
    logic [19:0] m_pend;
    logic [19:0] m_disp;
    bit          m_flag;

    ssd_scan_driver #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_word   (sym_word),
        .sym_valid  (sym_valid),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [4:0] s);
        logic [6:0] t [0:31];
        for (int i = 0; i < 32; i++) t[i] = 7'h7F;
        t[0] = 7'h01; t[1] = 7'h4F; t[2] = 7'h12; t[3] = 7'h06; t[4] = 7'h4C;
        t[5] = 7'h24; t[6] = 7'h20; t[7] = 7'h0F; t[8] = 7'h00; t[9] = 7'h04;
        t[11] = 7'h48; t[12] = 7'h6A; t[13] = 7'h71; t[14] = 7'h30; t[15] = 7'h31;
        t[16] = 7'h08; t[17] = 7'h7E; t[18] = 7'h18; t[19] = 7'h24; t[20] = 7'h42;
        return t[s];
    endfunction

    function automatic logic [19:0] word4(input int d3, input int d2, input int d1, input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    task automatic model_reset();
        n      = 0;
        m_pend = {4{5'd10}};
        m_disp = {4{5'd10}};
        m_flag = 1'b0;
    endtask

    // One clock: predict from pre-edge state and inputs, then compare at the falling edge
    task automatic cycle();
        int         d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_fd;
        logic       boundary;
        @(posedge clk);
        d     = (n / RDIV) % 4;
        e_an  = ~(4'b0001 << d);
        e_seg = seg_of(m_disp[d*5 +: 5]);
`ifdef SSD_BLINK_EN
        if (((n / BDIV) % 2) == 1 && blink_mask[d]) e_seg = 7'h7F;
`endif
        boundary = ((n % FRAME) == FRAME - 1);
        e_fd     = boundary;
        if (boundary) begin
            if (sym_valid) begin
                m_disp = sym_word;
                m_pend = sym_word;
            end else if (m_flag) begin
                m_disp = m_pend;
            end
            m_flag = 1'b0;
        end else if (sym_valid) begin
            m_pend = sym_word;
            m_flag = 1'b1;
        end
        n++;
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    // Advance until the next edge falls at the given position within the frame
    task automatic wait_phase(input int p);
        for (int i = 0; i < FRAME && (n % FRAME) != p; i++) cycle();
    endtask

    task automatic strobe(input logic [19:0] w);
        sym_word  = w;
        sym_valid = 1'b1;
        cycle();
        sym_valid = 1'b0;
        sym_word  = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'h0000000F);
        check({tag, "_seg"}, 32'(seg), 32'h0000007F);
        check({tag, "_fd"}, 32'(frame_done), 32'h00000000);
    endtask

    initial begin
        rst        = 1'b1;
        sym_word   = '0;
        sym_valid  = 1'b0;
        blink_mask = 4'b0000;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst = 1'b0;

        // Idle scan, all blank
        run(3 * FRAME);

        // Mid-frame load only appears from the next frame
        wait_phase(5);
        strobe(word4(15, 13, 19, 20));
        run(2 * FRAME);

        // Later strobe in the same frame wins
        wait_phase(2);
        strobe(word4(0, 0, 0, 1));
        wait_phase(9);
        strobe(word4(17, 17, 17, 17));
        run(2 * FRAME);

        // Strobe exactly on the boundary bypasses the pending register
        wait_phase(FRAME - 1);
        strobe(word4(1, 1, 1, 1));
        run(FRAME + 4);

        // Blink request on digit 3 with all eights
        blink_mask = 4'b1000;
        strobe(word4(8, 8, 8, 8));
        run(4 * BDIV);
        blink_mask = 4'b0000;

        // Reset while digit 2 is lit and a word is pending
        wait_phase(1);
        strobe(word4(3, 3, 3, 3));
        wait_phase(10);
        check("pend_before_rst_an", 32'(an), 32'h0000000B);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("rst_mid");
        end
        rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sym_valid  = ($urandom_range(0, 7) == 0);
            sym_word   = $urandom;
            blink_mask = 4'($urandom);
            cycle();
        end
        sym_valid = 1'b0;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
